// File: rtl/round_ctrl.sv
// rtl/round_ctrl.sv - tug-of-war round controller: random delay, go lights, first-push detection
module round_ctrl #(
  parameter int TICK_DIV   = 50000,
  parameter int DELAY_MIN  = 100,
  parameter int RAND_BITS  = 8,
  parameter int HOLD_TICKS = 500
) (
  input  logic clk,
  input  logic rst,
  input  logic pbl,
  input  logic pbr,
  output logic winrnd,
  output logic right,
  output logic tie,
  output logic leds_on
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int DLY_W = $clog2(DELAY_MIN + (1 << RAND_BITS));
  localparam int HLD_W = $clog2(HOLD_TICKS + 1);

  typedef enum logic [1:0] {ARM, DELAY, LIT, HOLD} state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] presc_q, presc_d;
  logic [DLY_W-1:0] dly_q, dly_d;
  logic [HLD_W-1:0] hold_q, hold_d;
  logic [7:0]       lfsr_q, lfsr_d;
  logic             pbl_q, pbl_d;
  logic             pbr_q, pbr_d;
  logic             winrnd_q, winrnd_d;
  logic             right_q, right_d;
  logic             tie_q, tie_d;
  logic             leds_q, leds_d;

  logic el, er, edge_any, tick;

  // Next-state logic: edge detect, prescaler tick, LFSR step and round sequencing.
  always_comb begin
    el       = pbl & ~pbl_q;
    er       = pbr & ~pbr_q;
    edge_any = el | er;
    tick     = (presc_q == PRE_W'(TICK_DIV - 1));

    // x^8+x^6+x^5+x^4+1; a non-zero seed never reaches the all-zero lock-up state
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    pbl_d  = pbl;
    pbr_d  = pbr;

    state_d  = state_q;
    dly_d    = dly_q;
    hold_d   = hold_q;
    winrnd_d = 1'b0;
    right_d  = right_q;
    tie_d    = tie_q;
    leds_d   = leds_q;

    case (state_q)
      ARM: begin
        leds_d = 1'b0;
        // both buttons must be released so a held button cannot start a round
        if (!pbl && !pbr) begin
          dly_d   = DLY_W'(DELAY_MIN) + DLY_W'(lfsr_q[RAND_BITS-1:0]);
          state_d = DELAY;
        end
      end
      DELAY: begin
        leds_d = 1'b0;
        // a push wins over expiry in the same cycle: it is a jump, lights stay off
        if (edge_any) begin
          winrnd_d = 1'b1;
          right_d  = er & ~el;
          tie_d    = el & er;
          hold_d   = '0;
          state_d  = HOLD;
        end else if (tick) begin
          if (dly_q <= DLY_W'(1)) begin
            leds_d  = 1'b1;
            state_d = LIT;
          end else begin
            dly_d = dly_q - DLY_W'(1);
          end
        end
      end
      LIT: begin
        leds_d = 1'b1;
        if (edge_any) begin
          winrnd_d = 1'b1;
          right_d  = er & ~el;
          tie_d    = el & er;
          hold_d   = '0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        // leds_on keeps the light state captured at the push
        if (tick) begin
          if (hold_q == HLD_W'(HOLD_TICKS - 1)) begin
            hold_d  = '0;
            leds_d  = 1'b0;
            state_d = ARM;
          end else begin
            hold_d = hold_q + HLD_W'(1);
          end
        end
      end
      default: begin
        leds_d  = 1'b0;
        state_d = ARM;
      end
    endcase

    // every state starts with a full tick period
    presc_d = tick ? '0 : presc_q + PRE_W'(1);
    if (state_d != state_q) begin
      presc_d = '0;
    end
  end

  // State and registered outputs; reset abandons any round in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ARM;
      presc_q  <= '0;
      dly_q    <= '0;
      hold_q   <= '0;
      lfsr_q   <= 8'h01;
      pbl_q    <= 1'b0;
      pbr_q    <= 1'b0;
      winrnd_q <= 1'b0;
      right_q  <= 1'b0;
      tie_q    <= 1'b0;
      leds_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      dly_q    <= dly_d;
      hold_q   <= hold_d;
      lfsr_q   <= lfsr_d;
      pbl_q    <= pbl_d;
      pbr_q    <= pbr_d;
      winrnd_q <= winrnd_d;
      right_q  <= right_d;
      tie_q    <= tie_d;
      leds_q   <= leds_d;
    end
  end

  assign winrnd  = winrnd_q;
  assign right   = right_q;
  assign tie     = tie_q;
  assign leds_on = leds_q;

endmodule
